// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: mux select codes,
// Tuse/Tnew encodings and the shadow-pipeline stage record.
package hazard_pkg;

  // Forwarding mux select codes
  localparam logic [1:0] FWD_GRF = 2'b00;
  localparam logic [1:0] FWD_M   = 2'b01;
  localparam logic [1:0] FWD_W   = 2'b10;
  localparam logic [1:0] FWD_PC8 = 2'b11;

  // Stages until a source operand is consumed
  localparam logic [1:0] TUSE_BRANCH = 2'd0;
  localparam logic [1:0] TUSE_ALU    = 2'd1;
  localparam logic [1:0] TUSE_STORE  = 2'd2;
  localparam logic [1:0] TUSE_NONE   = 2'd3;

  // Stages until a result is available, counted from E
  localparam logic [1:0] TNEW_PC8  = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] a3;
    logic [1:0] tnew;
  } stage_rec_t;

  // A producer matches a source only when it really writes a register
  function automatic logic reg_hit(logic [4:0] a3, logic [4:0] src);
    return (a3 != 5'd0) && (a3 == src);
  endfunction

  // Tnew shrinks by one per stage advanced, saturating at zero
  function automatic logic [1:0] age_tnew(logic [1:0] tnew);
    return (tnew == 2'd0) ? 2'd0 : tnew - 2'd1;
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Busy counter for the multi-cycle mult/div unit: loads the operation latency
// when a mult/div sits in E and counts down to idle.
module md_busy_counter #(
  parameter int unsigned MultCycles = 5,
  parameter int unsigned DivCycles  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic is_div_i,
  output logic busy_o
);

  localparam int unsigned MaxCycles = (DivCycles > MultCycles) ? DivCycles : MultCycles;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Reload on a new operation, otherwise drain towards zero
  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = is_div_i ? CntW'(DivCycles) : CntW'(MultCycles);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard controller for the 5-stage pipeline: shadows {rs, rt, a3, tnew} of the
// E/M/W instructions, selects forwarding sources and raises stall/flush.
module hazard_forward_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [1:0] tuse_rs_d,
  input  logic [1:0] tuse_rt_d,
  input  logic [4:0] a3_d,
  input  logic [1:0] tnew_d,
  input  logic       md_start_d,
  input  logic       md_is_div_d,
  input  logic       md_use_d,
  output logic [1:0] forward_rs_d,
  output logic [1:0] forward_rt_d,
  output logic [1:0] forward_rs_e,
  output logic [1:0] forward_rt_e,
  output logic [1:0] forward_rt_m,
  output logic       stall,
  output logic       flush_e,
  output logic       md_busy
);

  stage_rec_t rec_e_q, rec_e_d;
  stage_rec_t rec_m_q, rec_m_d;
  stage_rec_t rec_w_q, rec_w_d;
  logic       md_start_e_q, md_is_div_e_q;
  logic       stall_rs, stall_rt, stall_md;

  // W never forwards its own sources and its tnew is always zero
  logic unused_rec;
  assign unused_rec = ^{rec_w_q.rs, rec_w_q.rt, rec_w_q.tnew, rec_m_q.rs};

  md_busy_counter #(
    .MultCycles(MULT_CYCLES),
    .DivCycles (DIV_CYCLES)
  ) u_md_cnt (
    .clk     (clk),
    .reset   (reset),
    .start_i (md_start_e_q),
    .is_div_i(md_is_div_e_q),
    .busy_o  (md_busy)
  );

  // Stall decision: operand needed before its producer can supply it, or HI/LO busy
  always_comb begin
    stall_rs = (reg_hit(rec_e_q.a3, rs_d) && (tuse_rs_d < rec_e_q.tnew)) ||
               (reg_hit(rec_m_q.a3, rs_d) && (tuse_rs_d < rec_m_q.tnew));
    stall_rt = (reg_hit(rec_e_q.a3, rt_d) && (tuse_rt_d < rec_e_q.tnew)) ||
               (reg_hit(rec_m_q.a3, rt_d) && (tuse_rt_d < rec_m_q.tnew));
    stall_md = md_use_d && (md_busy || md_start_e_q);
    stall    = stall_rs || stall_rt || stall_md;
    flush_e  = stall;
  end

  // Forwarding selects, nearest ready producer wins
  always_comb begin
    forward_rs_d = FWD_GRF;
    if (reg_hit(rec_e_q.a3, rs_d) && rec_e_q.tnew == 2'd0)      forward_rs_d = FWD_PC8;
    else if (reg_hit(rec_m_q.a3, rs_d) && rec_m_q.tnew == 2'd0) forward_rs_d = FWD_M;
    else if (reg_hit(rec_w_q.a3, rs_d))                         forward_rs_d = FWD_W;

    forward_rt_d = FWD_GRF;
    if (reg_hit(rec_e_q.a3, rt_d) && rec_e_q.tnew == 2'd0)      forward_rt_d = FWD_PC8;
    else if (reg_hit(rec_m_q.a3, rt_d) && rec_m_q.tnew == 2'd0) forward_rt_d = FWD_M;
    else if (reg_hit(rec_w_q.a3, rt_d))                         forward_rt_d = FWD_W;

    forward_rs_e = FWD_GRF;
    if (reg_hit(rec_m_q.a3, rec_e_q.rs) && rec_m_q.tnew == 2'd0) forward_rs_e = FWD_M;
    else if (reg_hit(rec_w_q.a3, rec_e_q.rs))                    forward_rs_e = FWD_W;

    forward_rt_e = FWD_GRF;
    if (reg_hit(rec_m_q.a3, rec_e_q.rt) && rec_m_q.tnew == 2'd0) forward_rt_e = FWD_M;
    else if (reg_hit(rec_w_q.a3, rec_e_q.rt))                    forward_rt_e = FWD_W;

    forward_rt_m = reg_hit(rec_w_q.a3, rec_m_q.rt) ? FWD_W : FWD_GRF;
  end

  // Shadow pipeline next state; a stall injects a bubble into E
  always_comb begin
    rec_e_d      = stall ? '0 : '{rs: rs_d, rt: rt_d, a3: a3_d, tnew: tnew_d};
    rec_m_d      = rec_e_q;
    rec_m_d.tnew = age_tnew(rec_e_q.tnew);
    rec_w_d      = rec_m_q;
    rec_w_d.tnew = 2'd0;
  end

  // Stage record and mult/div start registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rec_e_q       <= '0;
      rec_m_q       <= '0;
      rec_w_q       <= '0;
      md_start_e_q  <= 1'b0;
      md_is_div_e_q <= 1'b0;
    end else begin
      rec_e_q       <= rec_e_d;
      rec_m_q       <= rec_m_d;
      rec_w_q       <= rec_w_d;
      md_start_e_q  <= md_start_d && !stall;
      md_is_div_e_q <= md_is_div_d && !stall;
    end
  end

endmodule
